// File: rtl/gbuff_b_loader.sv
// Write-side loader: streams weight words into NUM_BANKS B-buffer banks over a shared write bus.
// Latency 1 cycle accept->write strobe; in_ready is high only in LOAD, so producers stall otherwise.
module gbuff_b_loader #(
  parameter int ADDR_BITS = 16,
  parameter int DATA_BITS = 32,
  parameter int NUM_BANKS = 4,
  parameter int LEN_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_BITS-1:0]  cfg_len,
  input  logic [ADDR_BITS-1:0] cfg_base,
  input  logic                 cfg_mode,
  input  logic [ADDR_BITS-1:0] cfg_depth,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 wr_en,
  output logic [ADDR_BITS-1:0] index,
  output logic [DATA_BITS-1:0] data_in,
  output logic [2:0]           buf_idx,
  output logic                 busy,
  output logic                 done,
  output logic [LEN_BITS-1:0]  words_loaded
);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  localparam logic [2:0]           LAST_BANK = 3'(NUM_BANKS - 1);
  localparam logic [ADDR_BITS-1:0] ONE_A     = 1;
  localparam logic [LEN_BITS-1:0]  ONE_L     = 1;

  state_t                 state;
  logic [LEN_BITS-1:0]    len_r;
  logic [ADDR_BITS-1:0]   depth_r;
  logic                   mode_r;
  logic [ADDR_BITS-1:0]   idx;
  logic [ADDR_BITS-1:0]   blk_base;
  logic [ADDR_BITS-1:0]   cnt;
  logic [2:0]             bank;
  logic [ADDR_BITS-1:0]   depth_eff;
  logic [ADDR_BITS-1:0]   blk_next;
  logic                   hs;

  assign in_ready  = (state == LOAD);
  assign hs        = in_valid && in_ready;
  assign depth_eff = (depth_r == '0) ? ONE_A : depth_r;
  // In blocked mode each full pass over the banks moves the block window up by one depth,
  // so an overrun lands beyond the region the first pass wrote.
  assign blk_next  = blk_base + depth_eff;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      len_r        <= '0;
      depth_r      <= '0;
      mode_r       <= 1'b0;
      idx          <= '0;
      blk_base     <= '0;
      cnt          <= '0;
      bank         <= '0;
      wr_en        <= 1'b0;
      index        <= '0;
      data_in      <= '0;
      buf_idx      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      words_loaded <= '0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            len_r        <= cfg_len;
            depth_r      <= cfg_depth;
            mode_r       <= cfg_mode;
            idx          <= cfg_base;
            blk_base     <= cfg_base;
            cnt          <= '0;
            bank         <= '0;
            words_loaded <= '0;
            busy         <= 1'b1;
            if (cfg_len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (hs) begin
            wr_en        <= 1'b1;
            data_in      <= in_data;
            index        <= idx;
            buf_idx      <= bank;
            words_loaded <= words_loaded + ONE_L;
            if (!mode_r) begin
              if (bank == LAST_BANK) begin
                bank <= '0;
                idx  <= idx + ONE_A;
              end else begin
                bank <= bank + 3'd1;
              end
            end else if (cnt + ONE_A == depth_eff) begin
              cnt <= '0;
              if (bank == LAST_BANK) begin
                bank     <= '0;
                blk_base <= blk_next;
                idx      <= blk_next;
              end else begin
                bank <= bank + 3'd1;
                idx  <= blk_base;
              end
            end else begin
              cnt <= cnt + ONE_A;
              idx <= idx + ONE_A;
            end
            if (words_loaded + ONE_L == len_r) state <= FLUSH;
          end
        end
        FLUSH: begin
          state <= DONE;
          done  <= 1'b1;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gbuff_b_loader.sv
// Directed bench for gbuff_b_loader; a second NUM_BANKS=1 instance shares the inputs for the wrap case.
module tb_gbuff_b_loader;

  logic        clk = 1'b0;
  logic        rst_n, start, cfg_mode, in_valid;
  logic [15:0] cfg_len, cfg_base, cfg_depth;
  logic [31:0] in_data;

  logic        in_ready, wr_en, busy, done;
  logic [15:0] index, words_loaded;
  logic [31:0] data_in;
  logic [2:0]  buf_idx;

  logic        w_in_ready, w_wr_en, w_busy, w_done;
  logic [15:0] w_index, w_words_loaded;
  logic [31:0] w_data_in;
  logic [2:0]  w_buf_idx;

  int total = 0;
  int bad   = 0;

  logic [2:0]  q_bank[$];
  logic [15:0] q_idx[$];
  logic [31:0] q_dat[$];
  int          q_wcyc[$];
  int          q_acyc[$];
  logic [15:0] w_idx_q[$];
  logic [2:0]  w_bank_q[$];
  int          done_cnt, done_cyc, sent;

  always #5 clk = ~clk;

  gbuff_b_loader #(.ADDR_BITS(16), .DATA_BITS(32), .NUM_BANKS(4), .LEN_BITS(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .cfg_base(cfg_base),
    .cfg_mode(cfg_mode), .cfg_depth(cfg_depth), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .wr_en(wr_en), .index(index), .data_in(data_in), .buf_idx(buf_idx),
    .busy(busy), .done(done), .words_loaded(words_loaded)
  );

  gbuff_b_loader #(.ADDR_BITS(16), .DATA_BITS(32), .NUM_BANKS(1), .LEN_BITS(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .cfg_base(cfg_base),
    .cfg_mode(cfg_mode), .cfg_depth(cfg_depth), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_data(in_data), .wr_en(w_wr_en), .index(w_index), .data_in(w_data_in), .buf_idx(w_buf_idx),
    .busy(w_busy), .done(w_done), .words_loaded(w_words_loaded)
  );

  // Runs one transfer for a fixed 48-cycle window, sampling on falling edges.
  // Cycle c's sample reflects the rising edge that follows the drive at cycle c-1.
  task automatic run_xfer(input logic mode, input logic [15:0] base, input logic [15:0] depth,
                          input logic [15:0] len, input logic [31:0] vpat,
                          input logic [31:0] dbase, input int spur);
    q_bank.delete(); q_idx.delete(); q_dat.delete(); q_wcyc.delete(); q_acyc.delete();
    w_idx_q.delete(); w_bank_q.delete();
    done_cnt = 0; done_cyc = -1; sent = 0;
    @(negedge clk);
    start = 1'b1; cfg_mode = mode; cfg_base = base; cfg_depth = depth; cfg_len = len;
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    for (int cyc = 0; cyc < 48; cyc++) begin
      @(negedge clk);
      if (wr_en) begin
        q_bank.push_back(buf_idx); q_idx.push_back(index);
        q_dat.push_back(data_in);  q_wcyc.push_back(cyc);
      end
      if (w_wr_en) begin
        w_idx_q.push_back(w_index); w_bank_q.push_back(w_buf_idx);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      start = (cyc == spur);
      if (cyc == spur) begin
        cfg_len = 16'd2; cfg_base = 16'h5555; cfg_mode = ~mode; cfg_depth = 16'd1;
      end
      in_valid = vpat[cyc % 32];
      in_data  = dbase + sent;
      if (in_valid && in_ready) begin
        sent++;
        q_acyc.push_back(cyc + 1);
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    cfg_len = '0; cfg_base = '0; cfg_depth = '0; cfg_mode = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({in_ready, wr_en, busy, done} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b want=0000", {in_ready, wr_en, busy, done});
    end
    total++;
    if ({index, data_in, buf_idx, words_loaded} !== '0) begin
      bad++; $display("FAIL reset_bus idx=%h dat=%h bank=%0d wl=%0d want all 0", index, data_in, buf_idx, words_loaded);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_idle_valid;
    int wr_seen = 0;
    int rdy_seen = 0;
    in_valid = 1'b1; in_data = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (wr_en) wr_seen++;
      if (in_ready) rdy_seen++;
    end
    in_valid = 1'b0;
    total++;
    if (wr_seen !== 0 || rdy_seen !== 0) begin
      bad++; $display("FAIL idle_valid wr=%0d rdy=%0d want 0 0", wr_seen, rdy_seen);
    end
  endtask

  task automatic test_interleave;
    run_xfer(1'b0, 16'h0010, 16'd0, 16'd8, 32'hFFFF_FFFF, 32'hA0, -1);
    total++;
    if (q_idx.size() !== 8 || sent !== 8) begin
      bad++; $display("FAIL m0_count writes=%0d accepts=%0d want 8", q_idx.size(), sent);
    end else begin
      for (int k = 0; k < 8; k++) begin
        total++;
        if (q_bank[k] !== 3'(k % 4) || q_idx[k] !== 16'(16 + k / 4) || q_dat[k] !== 32'(160 + k)) begin
          bad++; $display("FAIL m0_write%0d got=(%0d,%h,%h) want=(%0d,%h,%h)", k, q_bank[k], q_idx[k],
                          q_dat[k], k % 4, 16 + k / 4, 160 + k);
        end
      end
      total++;
      if (done_cnt !== 1 || done_cyc !== q_wcyc[7] + 1) begin
        bad++; $display("FAIL m0_done cnt=%0d at=%0d want 1 at %0d", done_cnt, done_cyc, q_wcyc[7] + 1);
      end
    end
    total++;
    if (words_loaded !== 16'd8 || busy !== 1'b0) begin
      bad++; $display("FAIL m0_end wl=%0d busy=%b want 8 0", words_loaded, busy);
    end
  endtask

  task automatic test_blocked;
    run_xfer(1'b1, 16'h0000, 16'd3, 16'd7, 32'hFFFF_FFFF, 32'hB0, -1);
    total++;
    if (q_idx.size() !== 7) begin
      bad++; $display("FAIL m1_count writes=%0d want 7", q_idx.size());
    end else begin
      for (int k = 0; k < 7; k++) begin
        total++;
        if (q_bank[k] !== 3'(k / 3) || q_idx[k] !== 16'(k % 3) || q_dat[k] !== 32'(176 + k)) begin
          bad++; $display("FAIL m1_write%0d got=(%0d,%h,%h) want=(%0d,%h,%h)", k, q_bank[k], q_idx[k],
                          q_dat[k], k / 3, k % 3, 176 + k);
        end
      end
    end
    total++;
    if (done_cnt !== 1 || words_loaded !== 16'd7) begin
      bad++; $display("FAIL m1_done cnt=%0d wl=%0d want 1 7", done_cnt, words_loaded);
    end
  endtask

  // Valid on every third cycle, plus a stray start mid-transfer that must be ignored.
  task automatic test_backpressure;
    run_xfer(1'b0, 16'h0020, 16'd0, 16'd4, 32'h4924_9249, 32'hC0, 2);
    total++;
    if (q_idx.size() !== 4 || q_acyc.size() !== 4) begin
      bad++; $display("FAIL bp_count writes=%0d accepts=%0d want 4", q_idx.size(), q_acyc.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (q_wcyc[k] !== 3 * k + 1 || q_wcyc[k] !== q_acyc[k] || q_dat[k] !== 32'(192 + k)
            || q_bank[k] !== 3'(k) || q_idx[k] !== 16'h0020) begin
          bad++; $display("FAIL bp_write%0d cyc=%0d dat=%h bank=%0d idx=%h want cyc=%0d dat=%h bank=%0d idx=0020",
                          k, q_wcyc[k], q_dat[k], q_bank[k], q_idx[k], 3 * k + 1, 192 + k, k);
        end
      end
    end
    total++;
    if (done_cnt !== 1 || words_loaded !== 16'd4) begin
      bad++; $display("FAIL bp_done cnt=%0d wl=%0d want 1 4", done_cnt, words_loaded);
    end
  endtask

  task automatic test_zero_len;
    run_xfer(1'b0, 16'h0040, 16'd0, 16'd0, 32'hFFFF_FFFF, 32'hD0, -1);
    total++;
    if (q_idx.size() !== 0) begin
      bad++; $display("FAIL zero_writes got=%0d want 0", q_idx.size());
    end
    total++;
    if (done_cnt !== 1 || done_cyc !== 0) begin
      bad++; $display("FAIL zero_done cnt=%0d at=%0d want 1 at 0", done_cnt, done_cyc);
    end
    total++;
    if (words_loaded !== 16'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL zero_end wl=%0d busy=%b want 0 0", words_loaded, busy);
    end
  endtask

  task automatic test_wrap;
    run_xfer(1'b0, 16'hFFFF, 16'd0, 16'd3, 32'hFFFF_FFFF, 32'hE0, -1);
    total++;
    if (w_idx_q.size() !== 3) begin
      bad++; $display("FAIL wrap_count got=%0d want 3", w_idx_q.size());
    end else begin
      total++;
      if (w_idx_q[0] !== 16'hFFFF || w_idx_q[1] !== 16'h0000 || w_idx_q[2] !== 16'h0001
          || w_bank_q[2] !== 3'd0) begin
        bad++; $display("FAIL wrap_idx got=%h,%h,%h bank=%0d want ffff,0000,0001 bank=0",
                        w_idx_q[0], w_idx_q[1], w_idx_q[2], w_bank_q[2]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int wr_seen = 0;
    int done_seen = 0;
    @(negedge clk);
    start = 1'b1; cfg_mode = 1'b0; cfg_base = 16'h0010; cfg_len = 16'd8; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 32'(i);
      @(negedge clk);
    end
    total++;
    if (words_loaded !== 16'd3 || wr_en !== 1'b1) begin
      bad++; $display("FAIL rst_mid_pre wl=%0d wr=%b want 3 1", words_loaded, wr_en);
    end
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({in_ready, wr_en, busy, done} !== 4'b0000
        || {index, data_in, buf_idx, words_loaded} !== '0) begin
      bad++; $display("FAIL rst_mid_out flags=%b idx=%h dat=%h bank=%0d wl=%0d want all 0",
                      {in_ready, wr_en, busy, done}, index, data_in, buf_idx, words_loaded);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (wr_en) wr_seen++;
      if (done) done_seen++;
    end
    in_valid = 1'b0;
    total++;
    if (wr_seen !== 0 || done_seen !== 0) begin
      bad++; $display("FAIL rst_mid_after wr=%0d done=%0d want 0 0", wr_seen, done_seen);
    end
  endtask

  initial begin
    test_reset();
    test_idle_valid();
    test_interleave();
    test_blocked();
    test_backpressure();
    test_zero_len();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
